// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, pipeline depth and address-width helper for the convolution sequencer
package conv_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT, DONE} conv_state_t;

    // read latency (1) plus product register (1)
    localparam int PIPE_LAT = 2;

    // a depth of 1 still needs a 1-bit address bus
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if: start/handshake and datapath-control bundle between the sequencer and the datapath
//   master (sequencer): in  conv_start, m_ready_y
//                       out xmem_addr, fmem_addr, en_mult, en_accum, reset_accum, m_valid_y, conv_done, busy
//   slave  (datapath):  mirror image of master
interface conv_seq_ctrl_if import conv_pkg::*; #(
    parameter int N = 128,
    parameter int M = 32
);

    localparam int X_AW = addr_w(N);
    localparam int F_AW = addr_w(M);

    logic            conv_start;
    logic            m_ready_y;
    logic [X_AW-1:0] xmem_addr;
    logic [F_AW-1:0] fmem_addr;
    logic            en_mult;
    logic            en_accum;
    logic            reset_accum;
    logic            m_valid_y;
    logic            conv_done;
    logic            busy;

    modport master (
        input  conv_start, m_ready_y,
        output xmem_addr, fmem_addr, en_mult, en_accum, reset_accum, m_valid_y, conv_done, busy
    );

    modport slave (
        output conv_start, m_ready_y,
        input  xmem_addr, fmem_addr, en_mult, en_accum, reset_accum, m_valid_y, conv_done, busy
    );

endinterface

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: output index k, tap index j and the registered X/F read addresses
//   clk, reset     clock, asynchronous active-high reset
//   load           start of an output: j <= 0, X address <= k
//   step           issue cycle: advance j and X address (held on the last tap)
//   k_inc, k_clr   next output / end of vector
//   xmem_addr      k+j, fmem_addr j
//   j_last, k_last terminal flags for the FSM
module conv_addr_gen import conv_pkg::*; #(
    parameter int N = 128,
    parameter int M = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 k_inc,
    input  logic                 k_clr,
    output logic [addr_w(N)-1:0] xmem_addr,
    output logic [addr_w(M)-1:0] fmem_addr,
    output logic                 j_last,
    output logic                 k_last
);

    localparam int X_AW = addr_w(N);
    localparam int F_AW = addr_w(M);
    localparam logic [X_AW-1:0] K_MAX = X_AW'(N - M);
    localparam logic [F_AW-1:0] J_MAX = F_AW'(M - 1);

    logic [X_AW-1:0] k_q, k_d, x_q, x_d;
    logic [F_AW-1:0] j_q, j_d;
    logic            adv;

    assign j_last    = j_q == J_MAX;
    assign k_last    = k_q == K_MAX;
    assign xmem_addr = x_q;
    assign fmem_addr = j_q;
    // holding on the last tap keeps k+j <= N-1 and j <= M-1
    assign adv       = step && !j_last;

    always_comb begin
        k_d = k_clr ? '0 : k_inc ? k_q + X_AW'(1) : k_q;
        j_d = load ? '0 : adv ? j_q + F_AW'(1) : j_q;
        x_d = load ? k_q : adv ? x_q + X_AW'(1) : x_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
            j_q <= '0;
            x_q <= '0;
        end else begin
            k_q <= k_d;
            j_q <= j_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences one 1-D convolution pass (N-M+1 outputs of M taps each) over the MAC datapath
//   clk, reset  clock, asynchronous active-high reset (returns to IDLE, all outputs 0)
//   bus         conv_seq_ctrl_if.master: conv_start/m_ready_y in; addresses, MAC enables,
//               accumulator clear, y valid, conv_done pulse and busy out
module conv_seq_ctrl import conv_pkg::*; #(
    parameter int N = 128,
    parameter int M = 32
) (
    input  logic            clk,
    input  logic            reset,
    conv_seq_ctrl_if.master bus
);

    conv_state_t         state_q, state_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                issue, hs, j_last, k_last;

    assign issue = state_q == MAC;
    assign hs    = state_q == OUT && bus.m_ready_y;

    always_comb begin
        pipe_d  = {pipe_q[PIPE_LAT-2:0], issue};
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.conv_start ? LOAD : IDLE;
            LOAD:    state_d = MAC;
            MAC:     state_d = j_last ? DRAIN : MAC;
            // the second drain cycle is the first one with the read stage already empty
            DRAIN:   state_d = pipe_q[0] ? DRAIN : OUT;
            OUT:     state_d = !bus.m_ready_y ? OUT : k_last ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.en_mult     = pipe_q[0];
    assign bus.en_accum    = pipe_q[PIPE_LAT-1];
    assign bus.reset_accum = state_q == LOAD;
    assign bus.m_valid_y   = state_q == OUT;
    assign bus.conv_done   = state_q == DONE;
    assign bus.busy        = state_q != IDLE;

    conv_addr_gen #(.N(N), .M(M)) u_addr (
        .clk       (clk),
        .reset     (reset),
        .load      (state_q == LOAD),
        .step      (issue),
        .k_inc     (hs && !k_last),
        .k_clr     (state_q == DONE),
        .xmem_addr (bus.xmem_addr),
        .fmem_addr (bus.fmem_addr),
        .j_last    (j_last),
        .k_last    (k_last)
    );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl in three sizes (128/32, 8/8, 4/1)
module tb_conv_seq_ctrl;

    typedef struct {
        int xa, fa;
        bit em, ea, ra, v, r, d, b, rst;
    } obs_t;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst_a = 1, rst_b = 1, rst_c = 1;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv_seq_ctrl_if #(.N(128), .M(32)) ia();
    conv_seq_ctrl_if #(.N(8),   .M(8))  ib();
    conv_seq_ctrl_if #(.N(4),   .M(1))  ic();

    conv_seq_ctrl #(.N(128), .M(32)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    conv_seq_ctrl #(.N(8),   .M(8))  dut_b (.clk(clk), .reset(rst_b), .bus(ib));
    conv_seq_ctrl #(.N(4),   .M(1))  dut_c (.clk(clk), .reset(rst_c), .bus(ic));

    obs_t o [3];
    always_comb begin
        o[0] = '{int'(ia.xmem_addr), int'(ia.fmem_addr), ia.en_mult, ia.en_accum, ia.reset_accum,
                 ia.m_valid_y, ia.m_ready_y, ia.conv_done, ia.busy, rst_a};
        o[1] = '{int'(ib.xmem_addr), int'(ib.fmem_addr), ib.en_mult, ib.en_accum, ib.reset_accum,
                 ib.m_valid_y, ib.m_ready_y, ib.conv_done, ib.busy, rst_b};
        o[2] = '{int'(ic.xmem_addr), int'(ic.fmem_addr), ic.en_mult, ic.en_accum, ic.reset_accum,
                 ic.m_valid_y, ic.m_ready_y, ic.conv_done, ic.busy, rst_c};
    end

    int hs_q [3][$];
    int dn_q [3][$];
    int tmo_q [$];
    int base [3];
    int kx [3];
    int jx [3];
    int na [3];
    obs_t prv [3];
    int n_cmp = 0, n_err = 0;
    bit fin = 0, fin_done = 0;

    function automatic int mval(input int g);
        return g == 0 ? 32 : (g == 1 ? 8 : 1);
    endfunction

    function automatic int hold_key(input obs_t s);
        return s.xa * 10000 + s.fa * 100 + int'(s.em) * 4 + int'(s.ea) * 2 + int'(s.ra);
    endfunction

    task automatic chk(input string nm, input int g, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cfg%0d: got %0d, expected %0d (cycle %0d)", nm, g, act, exp, cyc - base[g]);
        end
    endtask

    task automatic mon(input int g);
        obs_t c, p;
        c = o[g];
        p = prv[g];
        prv[g] = c;
        if (c.rst) begin
            chk("rst_zero", g, c.xa + c.fa + int'(c.em) + int'(c.ea) + int'(c.ra) + int'(c.v) + int'(c.d) + int'(c.b), 0);
            kx[g] = 0;
            jx[g] = 0;
            na[g] = 0;
            return;
        end
        if (p.v && !p.r && c.v) chk("stall_hold", g, hold_key(c), hold_key(p));
        if (c.em) begin
            chk("addr", g, p.xa * 1000 + p.fa, (kx[g] + jx[g]) * 1000 + jx[g]);
            jx[g]++;
        end
        if (c.ea || p.em) begin
            chk("accum_trail", g, int'(c.ea), int'(p.em));
            if (c.ea) na[g]++;
        end
        if (p.v && p.r) chk("resume", g, int'(c.ra | c.d), 1);
        if (c.v && c.r) begin
            if (hs_q[g].size() == 0) chk("y_extra", g, cyc - base[g], -1);
            else chk("y_time", g, cyc - base[g], hs_q[g].pop_front());
            chk("n_mult", g, jx[g], mval(g));
            chk("n_accum", g, na[g], mval(g));
            chk("busy", g, int'(c.b), 1);
            kx[g]++;
            jx[g] = 0;
            na[g] = 0;
        end
        if (c.d) begin
            if (dn_q[g].size() == 0) chk("done_extra", g, cyc - base[g], -1);
            else chk("done_time", g, cyc - base[g], dn_q[g].pop_front());
            kx[g] = 0;
        end
    endtask

    always @(negedge clk) begin
        while (tmo_q.size() != 0) chk("done_timeout", tmo_q.pop_front(), 0, 1);
        for (int g = 0; g < 3; g++) mon(g);
        if (fin && !fin_done) begin
            for (int g = 0; g < 3; g++) begin
                chk("y_left", g, hs_q[g].size(), 0);
                chk("done_left", g, dn_q[g].size(), 0);
            end
            fin_done = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_start(input int g, input logic v);
        case (g)
            0: ia.conv_start = v;
            1: ib.conv_start = v;
            default: ic.conv_start = v;
        endcase
    endtask

    task automatic set_ready(input int g, input logic v);
        case (g)
            0: ia.m_ready_y = v;
            1: ib.m_ready_y = v;
            default: ic.m_ready_y = v;
        endcase
    endtask

    // expected handshake cycles: period M+4, one stalled output delayed by stall_n
    task automatic push_run(input int g, input int outs, input int stall_k, input int stall_n, input bit with_done);
        int t = 0;
        for (int i = 0; i < outs; i++) begin
            t += mval(g) + 4;
            if (i == stall_k) t += stall_n;
            hs_q[g].push_back(t);
        end
        if (with_done) dn_q[g].push_back(t + 1);
    endtask

    task automatic start(input int g);
        set_start(g, 1);
        base[g] = cyc;
        tick(1);
        set_start(g, 0);
    endtask

    task automatic wait_until(input int g, input int c);
        while (cyc - base[g] < c) tick(1);
    endtask

    task automatic wait_done(input int g, input int lim);
        int i = 0;
        while (!o[g].d && i < lim) begin
            tick(1);
            i++;
        end
        if (!o[g].d) tmo_q.push_back(g);
        tick(2);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            set_start(g, 0);
            set_ready(g, 1);
        end
        tick(3);
        rst_a = 0;
        rst_b = 0;
        rst_c = 0;
        tick(2);
        fork
            begin
                push_run(0, 97, -1, 0, 1);
                start(0);
                for (int i = 1; i < 300; i++) begin
                    set_start(0, i[0]);
                    tick(1);
                end
                set_start(0, 0);
                wait_done(0, 4000);
            end
            begin
                push_run(1, 1, -1, 0, 1);
                start(1);
                wait_done(1, 100);
            end
            begin
                push_run(2, 4, -1, 0, 1);
                start(2);
                wait_done(2, 100);
            end
        join
        push_run(0, 97, 3, 10, 1);
        start(0);
        wait_until(0, 140);
        set_ready(0, 0);
        wait_until(0, 154);
        set_ready(0, 1);
        wait_done(0, 4000);
        push_run(0, 40, -1, 0, 0);
        start(0);
        wait_until(0, 1450);
        rst_a = 1;
        tick(3);
        rst_a = 0;
        tick(2);
        push_run(0, 97, -1, 0, 1);
        start(0);
        wait_done(0, 4000);
        fin = 1;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
